// File: rtl/seg7_if.sv
// Display-side bundle for seg7_scan: value/enable in, anode/segment drive out.
interface seg7_if;
  logic [31:0] data;
  logic [7:0]  digit_en;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        frame_start;

  modport master (output data, digit_en, input an, seg, frame_start);
  modport slave  (input data, digit_en, output an, seg, frame_start);
endinterface

// File: rtl/seg7_scan.sv
// Time-multiplexed 8-digit common-anode hex display driver with internal scan prescaler.
// Optional leading-zero blanking is built when SEG7_LZB_EN is defined.
module seg7_scan #(
  parameter int unsigned SCAN_DIV = 100_000,
  parameter int unsigned DIGITS   = 8
) (
  input  logic  clk,
  input  logic  rst,
  seg7_if.slave bus
);
  localparam logic [31:0] DIV_M1 = 32'(SCAN_DIV - 1);

  logic [31:0]     cnt;
  logic [2:0]      idx;
  logic [7:0][3:0] data_l;
  logic [7:0]      en_l;
  logic [7:0]      an_q;
  logic [6:0]      seg_q;
  logic            fs_q;

  logic            tick;
  logic [7:0][3:0] cur_data;
  logic [7:0]      cur_en;
  logic [3:0]      nib;
  logic            lit;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;  4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;  4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;  4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;  4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;  4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;  default: hex7 = 7'b0001110;
    endcase
  endfunction

  assign tick = (cnt == DIV_M1);

  // Digit 0 reads the live inputs so the frame it starts is already the new frame.
  always_comb begin
    cur_data = (idx == 3'd0) ? bus.data     : data_l;
    cur_en   = (idx == 3'd0) ? bus.digit_en : en_l;
    nib      = cur_data[idx];
    lit      = cur_en[idx];
`ifdef SEG7_LZB_EN
    begin
      logic [2:0] top;
      top = 3'd0;
      for (int k = 1; k < 8; k++)
        if (cur_data[k] != 4'h0) top = 3'(k);
      if (idx > top) lit = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      idx    <= '0;
      data_l <= '0;
      en_l   <= '0;
      an_q   <= 8'hFF;
      seg_q  <= 7'h7F;
      fs_q   <= 1'b0;
    end else begin
      cnt  <= tick ? '0 : cnt + 32'd1;
      fs_q <= 1'b0;
      if (tick) begin
        if (idx == 3'd0) begin
          data_l <= bus.data;
          en_l   <= bus.digit_en;
        end
        an_q  <= lit ? ~(8'b1 << idx) : 8'hFF;
        seg_q <= lit ? hex7(nib) : 7'h7F;
        fs_q  <= (idx == 3'd0);
        idx   <= idx + 3'd1;
      end
    end
  end

  assign bus.an          = an_q;
  assign bus.seg         = seg_q;
  assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_seg7_scan.sv
// Directed scoreboard bench for seg7_scan (SCAN_DIV=4 main DUT, SCAN_DIV=1 secondary DUT).
module tb_seg7_scan;
  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg7_if bus0 ();
  seg7_if bus1 ();

  seg7_scan #(.SCAN_DIV(DIV), .DIGITS(8)) u_dut  (.clk(clk), .rst(rst), .bus(bus0));
  seg7_scan #(.SCAN_DIV(1),   .DIGITS(8)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       fs;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errs   = 0;

  logic [6:0] hex_t [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic [31:0] m_data;
  logic [7:0]  m_en;
  int          m_idx;
  logic [7:0]  prev_an;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] d, input logic [7:0] en, input int i);
    exp_t e;
    int   top;
    logic lit;
    top = 0;
    for (int k = 1; k < 8; k++)
      if (d[k*4 +: 4] != 4'h0) top = k;
    lit = en[i];
`ifdef SEG7_LZB_EN
    if (i > top) lit = 1'b0;
`endif
    e.an  = lit ? (8'hFF ^ (8'h01 << i)) : 8'hFF;
    e.seg = lit ? hex_t[d[i*4 +: 4]] : 7'h7F;
    e.fs  = (i == 0);
    return e;
  endfunction

  // One digit slot: predict, let the prescaler run, then compare.
  task automatic do_slot(input string tag);
    exp_t e;
    if (m_idx == 0) begin
      m_data = bus0.data;
      m_en   = bus0.digit_en;
    end
    q.push_back(model(m_data, m_en, m_idx));
    m_idx = (m_idx + 1) % 8;
    @(posedge clk); #1;
    chk({tag, "_hold_an"}, 32'(bus0.an), 32'(prev_an));
    chk({tag, "_fs_low"},  32'(bus0.frame_start), 32'd0);
    repeat (DIV - 1) @(posedge clk);
    #1;
    e = q.pop_front();
    chk({tag, "_an"},  32'(bus0.an),  32'(e.an));
    chk({tag, "_seg"}, 32'(bus0.seg), 32'(e.seg));
    chk({tag, "_fs"},  32'(bus0.frame_start), 32'(e.fs));
    chk({tag, "_onehot"}, 32'($countones(~bus0.an) <= 1), 32'd1);
    prev_an = e.an;
  endtask

  task automatic do_frame(input string tag);
    for (int s = 0; s < 8; s++) do_slot(tag);
  endtask

  initial begin
    exp_t e;
    bus0.data = 32'h0123_4567; bus0.digit_en = 8'hFF;
    bus1.data = 32'h8765_4321; bus1.digit_en = 8'hFF;
    m_idx = 0; prev_an = 8'hFF; m_data = '0; m_en = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_an",  32'(bus0.an), 32'hFF);
    chk("rst_seg", 32'(bus0.seg), 32'h7F);
    chk("rst_fs",  32'(bus0.frame_start), 32'd0);
    rst = 1'b0;

    // First frame; data changes after digit 3 must not tear this frame.
    for (int s = 0; s < 8; s++) begin
      do_slot("f1");
      if (s == 3) bus0.data = 32'hFFFF_FFFF;
    end
    do_frame("f2_allF");

    bus0.data = 32'h0123_4567; bus0.digit_en = 8'h0F;
    do_frame("f3_en0F");

    bus0.digit_en = 8'hFF;
    for (int s = 0; s < 6; s++) do_slot("f4_pre");
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_an",  32'(bus0.an), 32'hFF);
    chk("midrst_seg", 32'(bus0.seg), 32'h7F);
    chk("midrst_fs",  32'(bus0.frame_start), 32'd0);
    rst = 1'b0; m_idx = 0; prev_an = 8'hFF;
    bus0.data = 32'h89AB_CDEF;
    do_frame("f5_after_rst");

`ifdef SEG7_LZB_EN
    bus0.data = 32'h0000_00A0;
    do_frame("lzb_A0");
    bus0.data = 32'h0000_0000;
    do_frame("lzb_zero");
`endif

    // Single-cycle prescaler: a new digit on every edge after release.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      e = model(32'h8765_4321, 8'hFF, k % 8);
      chk("div1_an",  32'(bus1.an),  32'(e.an));
      chk("div1_seg", 32'(bus1.seg), 32'(e.seg));
      chk("div1_fs",  32'(bus1.frame_start), 32'(e.fs));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end
endmodule

// File: doc/seg7_scan.md
Name: seg7_scan

Overview:
- Time-multiplexed driver for the board's 8-digit common-anode seven-segment display.
- Takes a 32-bit value from the CPU debug path (PC, register or bus value) and shows it as 8 hex digits.
- Scan rate comes from an internal prescaler on the system clock, so the block needs no derived clock.
- Sits directly downstream of the clock-division stage in the board top level, alongside the slow CPU clock.

Parameters:
- SCAN_DIV, 100_000: system-clock cycles per digit slot. At 100 MHz this gives 1 kHz per digit and 125 Hz per frame. Legal range is 1 to 2^32-1.
- DIGITS, 8: number of digits scanned. Fixed at 8; it is a parameter for documentation only.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- data  input  32  value to display; nibble k drives digit k (digit 0 is rightmost)
- digit_en  input  8  per-digit enable; 1 = digit may light
- an  output  8  digit anodes, active low, registered
- seg  output  7  segments {g,f,e,d,c,b,a}, active low, registered
- frame_start  output  1  one-cycle pulse, registered, asserted on the cycle digit 0 is driven

Behaviour:
- One clock, clk. Reset is synchronous and active-high, sampled on posedge clk.
- Reset state: prescaler count = 0, idx = 0, data_l = 0, en_l = 0, an = 8'hFF, seg = 7'h7F, frame_start = 0.
  - Reset asserted mid-scan returns to this state on the next edge.
  - No partial frame may resume after reset.
- Prescaler:
  - cnt counts 0 to SCAN_DIV-1.
  - tick is asserted combinationally when cnt == SCAN_DIV-1; on that edge cnt returns to 0.
  - With SCAN_DIV = 1, tick is asserted every cycle.
- Frame latch: on a tick edge with idx == 0, data_l <= data and en_l <= digit_en.
  - The digit 0 driven on that same edge uses the incoming data/digit_en (bypass), not the stale latch.
  - data and digit_en changes between frame starts are invisible until the next frame. No tearing.
- Digit output, on every tick edge:
  - Sel = idx.
  - If the enable bit for Sel is set: an <= ~(8'b1 << Sel) and seg <= hex decode of nibble Sel.
  - If the enable bit is clear: an <= 8'hFF and seg <= 7'h7F.
  - idx <= idx + 1, modulo 8 (7 wraps to 0).
- frame_start <= 1 on a tick edge with idx == 0, else 0.
- Latency: the first digit lights SCAN_DIV cycles after reset release. an/seg hold their value between ticks.
- Hex decode, active low, {g..a}:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110
- At most one an bit is low at any time.

Optional Feature:
- Macro SEG7_LZB_EN enables leading-zero blanking.
- When defined:
  - At frame latch, compute top = index of the highest non-zero nibble of the latched data (0 if data == 0).
  - Digits with index > top are blanked as if their enable bit were clear.
  - Digit 0 is never blanked by this rule; digit_en still applies.
- When undefined: every enabled digit is shown, including leading zeros.

Test Plan (SCAN_DIV = 4 unless stated):
- Reset → an = FF, seg = 7F, frame_start = 0. Release rst → first change on cycle 4: an = FE, frame_start = 1.
- data = 32'h0123_4567, digit_en = FF, run one frame → digits 0..7 show 7,6,5,4,3,2,1,0. seg sequence 1111000, 0000010, 0010010, 0011001, 0110000, 0100100, 1111001, 1000000. an walks FE, FD, FB, ..., 7F.
- Change data to 32'hFFFF_FFFF during digit 3 → digits 4..7 still show the old nibbles. Next frame shows all 0001110.
- digit_en = 8'h0F → slots 4..7 give an = FF, seg = 7F. Slots 0..3 are normal.
- Assert rst for 1 cycle during digit 5 → next cycle an = FF. Scan restarts at digit 0 after SCAN_DIV cycles.
- SEG7_LZB_EN, data = 32'h0000_00A0 → only digits 0 and 1 light (seg 1000000, then 0001000). Digits 2..7 give an = FF. With data = 0, only digit 0 lights, showing 1000000. With SCAN_DIV = 1, a digit advances every cycle.
